// File: rtl/gumnut_ctrl_fsm_if.sv
// rtl/gumnut_ctrl_fsm_if.sv - fetch, decode-field, datapath-control and bus signals of the Gumnut controller
interface gumnut_ctrl_fsm_if;
  logic        inst_stb_o;
  logic        inst_ack_i;
  logic [11:0] inst_adr_o;
  logic [2:0]  op_e;
  logic [2:0]  func_e;
  logic [11:0] addr_e;
  logic [7:0]  disp_e;
  logic        zero_e;
  logic        carry_e;
  logic        RegWrt_c;
  logic        ClkEn_e;
  logic [1:0]  RegMux_c;
  logic        op2_c;
  logic [3:0]  ALUOp_c;
  logic        data_stb_o;
  logic        port_stb_o;
  logic        bus_we_o;
  logic        data_ack_i;
  logic        port_ack_i;
  logic        halted_o;
  logic        err_o;
  logic [2:0]  state_o;

  modport master (
    output inst_stb_o, inst_adr_o, RegWrt_c, ClkEn_e, RegMux_c, op2_c, ALUOp_c,
           data_stb_o, port_stb_o, bus_we_o, halted_o, err_o, state_o,
    input  inst_ack_i, op_e, func_e, addr_e, disp_e, zero_e, carry_e, data_ack_i, port_ack_i
  );

  modport slave (
    input  inst_stb_o, inst_adr_o, RegWrt_c, ClkEn_e, RegMux_c, op2_c, ALUOp_c,
           data_stb_o, port_stb_o, bus_we_o, halted_o, err_o, state_o,
    output inst_ack_i, op_e, func_e, addr_e, disp_e, zero_e, carry_e, data_ack_i, port_ack_i
  );
endinterface

// File: rtl/gumnut_ctrl_fsm.sv
// rtl/gumnut_ctrl_fsm.sv - multi-cycle Gumnut control unit: PC, fetch, bus handshakes, branches, return stack
module gumnut_ctrl_fsm #(
  parameter int RS_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  gumnut_ctrl_fsm_if.master bus
);
  localparam int RS_AW = $clog2(RS_DEPTH);
  localparam logic [RS_AW:0] RS_FULL = (RS_AW+1)'(RS_DEPTH);

  localparam logic [2:0] OP_ALU   = 3'b000;
  localparam logic [2:0] OP_IMM   = 3'b001;
  localparam logic [2:0] OP_SHIFT = 3'b010;
  localparam logic [2:0] OP_MEM   = 3'b011;
  localparam logic [2:0] OP_BR    = 3'b100;
  localparam logic [2:0] OP_JMP   = 3'b101;
  localparam logic [2:0] OP_MISC  = 3'b110;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [11:0]      pc, pc_nxt;
  logic [11:0]      rs_mem [RS_DEPTH];
  logic [RS_AW-1:0] rs_ptr, rs_top_idx;
  logic [RS_AW:0]   rs_cnt;
  logic             z_flag, c_flag, err;
  logic             err_set, flag_ld, rs_push, rs_pop, br_taken;

  assign rs_top_idx = rs_ptr - RS_AW'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= FETCH;
      pc     <= 12'h000;
      rs_ptr <= '0;
      rs_cnt <= '0;
      z_flag <= 1'b0;
      c_flag <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (flag_ld) begin
        z_flag <= bus.zero_e;
        c_flag <= bus.carry_e;
      end
      if (err_set) err <= 1'b1;
      // A full stack keeps advancing the pointer, so the oldest slot is the one overwritten
      if (rs_push) begin
        rs_ptr <= rs_ptr + RS_AW'(1);
        if (rs_cnt == RS_FULL) err <= 1'b1;
        else                   rs_cnt <= rs_cnt + (RS_AW+1)'(1);
      end else if (rs_pop) begin
        rs_ptr <= rs_top_idx;
        rs_cnt <= rs_cnt - (RS_AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rs_push) rs_mem[rs_ptr] <= pc;
  end

  always_comb begin
    br_taken = 1'b0;
    unique case (bus.func_e[1:0])
      2'b00: br_taken = z_flag;
      2'b01: br_taken = !z_flag;
      2'b10: br_taken = c_flag;
      2'b11: br_taken = !c_flag;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    err_set         = 1'b0;
    flag_ld         = 1'b0;
    rs_push         = 1'b0;
    rs_pop          = 1'b0;
    bus.inst_stb_o  = 1'b0;
    bus.RegWrt_c    = 1'b0;
    bus.ClkEn_e     = 1'b0;
    bus.RegMux_c    = 2'b00;
    bus.op2_c       = 1'b1;
    bus.ALUOp_c     = 4'b0000;
    bus.data_stb_o  = 1'b0;
    bus.port_stb_o  = 1'b0;
    bus.bus_we_o    = 1'b0;

    // ALU controls stay valid through WB since the decoded fields hold until the next fetch
    if ((state == EXEC || state == WB) &&
        (bus.op_e == OP_ALU || bus.op_e == OP_IMM || bus.op_e == OP_SHIFT)) begin
      bus.ALUOp_c = (bus.op_e == OP_SHIFT) ? {2'b10, bus.func_e[1:0]} : {1'b0, bus.func_e};
      bus.op2_c   = (bus.op_e == OP_ALU);
    end

    unique case (state)
      FETCH: begin
        bus.inst_stb_o = !rst_i;
        if (bus.inst_ack_i) begin
          pc_nxt    = pc + 12'd1;
          state_nxt = DECODE;
        end
      end
      DECODE: state_nxt = EXEC;
      EXEC: begin
        state_nxt = FETCH;
        unique case (bus.op_e)
          OP_ALU, OP_IMM, OP_SHIFT: state_nxt = WB;
          OP_MEM: begin
            bus.op2_c = 1'b0;
            if (bus.func_e[2]) err_set   = 1'b1;
            else               state_nxt = MEM;
          end
          OP_BR: if (br_taken) pc_nxt = pc + {{4{bus.disp_e[7]}}, bus.disp_e};
          OP_JMP: begin
            rs_push = bus.func_e[0];
            pc_nxt  = bus.addr_e;
          end
          OP_MISC: begin
            if (bus.func_e == 3'b000) begin
              if (rs_cnt == '0) err_set = 1'b1;
              else begin
                rs_pop = 1'b1;
                pc_nxt = rs_mem[rs_top_idx];
              end
            end else if (bus.func_e == 3'b001) begin
              state_nxt = HALT;
            end
          end
          default: err_set = 1'b1;
        endcase
      end
      MEM: begin
        bus.op2_c      = 1'b0;
        bus.data_stb_o = !bus.func_e[1];
        bus.port_stb_o = bus.func_e[1];
        bus.bus_we_o   = bus.func_e[0];
        if (bus.func_e[1] ? bus.port_ack_i : bus.data_ack_i) begin
          state_nxt = FETCH;
          if (!bus.func_e[0]) begin
            bus.RegWrt_c = 1'b1;
            bus.ClkEn_e  = 1'b1;
            bus.RegMux_c = bus.func_e[1] ? 2'b10 : 2'b01;
          end
        end
      end
      WB: begin
        bus.RegWrt_c = 1'b1;
        bus.ClkEn_e  = 1'b1;
        flag_ld      = 1'b1;
        state_nxt    = FETCH;
      end
      HALT: state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  assign bus.inst_adr_o = pc;
  assign bus.halted_o   = (state == HALT);
  assign bus.err_o      = err;
  assign bus.state_o    = state;
endmodule

// File: tb/tb_gumnut_ctrl_fsm.sv
// tb/tb_gumnut_ctrl_fsm.sv - scoreboard bench for gumnut_ctrl_fsm
module tb_gumnut_ctrl_fsm;
  localparam int RS_DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_ack = 0;

  typedef struct {
    logic [11:0] adr;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] m_rs[$];
  logic [11:0] m_pc;
  logic        m_z, m_c, m_err;

  gumnut_ctrl_fsm_if dut_if();

  gumnut_ctrl_fsm #(.RS_DEPTH(RS_DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (dut_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dut_if.inst_ack_i = 1'b0;
    dut_if.data_ack_i = 1'b0;
    dut_if.port_ack_i = 1'b0;
    dut_if.op_e = 3'b000;
    dut_if.func_e = 3'b000;
    dut_if.addr_e = 12'h000;
    dut_if.disp_e = 8'h00;
    dut_if.zero_e = 1'b0;
    dut_if.carry_e = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_inst_stb", dut_if.inst_stb_o, 0);
    check("rst_state", dut_if.state_o, 0);
    check("rst_adr", dut_if.inst_adr_o, 0);
    check("rst_regwrt", {dut_if.RegWrt_c, dut_if.ClkEn_e, dut_if.data_stb_o, dut_if.port_stb_o}, 0);
    check("rst_op2", dut_if.op2_c, 1);
    check("rst_aluop", {dut_if.RegMux_c, dut_if.ALUOp_c}, 0);
    check("rst_err_halt", {dut_if.err_o, dut_if.halted_o}, 0);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back('{12'h000, 0});
    m_rs.delete();
    m_pc = 12'h000;
    m_z = 1'b0;
    m_c = 1'b0;
    m_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_inst(input logic [2:0] op, input logic [2:0] func, input logic [11:0] addr,
                          input logic [7:0] disp, input logic z_in, input logic c_in, input int waits);
    exp_t        e;
    int          n, w, rw, ce, dstb, pstb, we, lat, nstb, erw, edstb, epstb, ewe;
    logic [1:0]  mux, emux;
    logic [3:0]  aluop, ealu;
    logic        op2, eop2, halt, taken;
    n = 0;
    while (!dut_if.inst_stb_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_seen", dut_if.inst_stb_o, 1);
    if (!dut_if.inst_stb_o) return;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("fetch_adr", dut_if.inst_adr_o, e.adr);
      if (e.lat > 0) check("latency", cyc - last_ack, e.lat);
    end
    last_ack = cyc;
    dut_if.inst_ack_i = 1'b1;
    dut_if.op_e = op;
    dut_if.func_e = func;
    dut_if.addr_e = addr;
    dut_if.disp_e = disp;
    dut_if.zero_e = z_in;
    dut_if.carry_e = c_in;
    @(negedge clk);
    dut_if.inst_ack_i = 1'b0;

    m_pc = m_pc + 12'd1;
    lat = 3; erw = 0; emux = 2'b00; ealu = 4'b0000; eop2 = 1'b0;
    edstb = 0; epstb = 0; ewe = 0; halt = 1'b0;
    case (op)
      3'b000, 3'b001, 3'b010: begin
        lat = 4; erw = 1;
        ealu = (op == 3'b010) ? {2'b10, func[1:0]} : {1'b0, func};
        eop2 = (op == 3'b000);
        m_z = z_in; m_c = c_in;
      end
      3'b011: begin
        if (func[2]) m_err = 1'b1;
        else begin
          lat = 4 + waits;
          nstb = waits + 1;
          if (func[1]) epstb = nstb; else edstb = nstb;
          if (func[0]) ewe = nstb;
          else begin
            erw = 1;
            emux = func[1] ? 2'b10 : 2'b01;
          end
        end
      end
      3'b100: begin
        case (func[1:0])
          2'b00: taken = m_z;
          2'b01: taken = !m_z;
          2'b10: taken = m_c;
          default: taken = !m_c;
        endcase
        if (taken) m_pc = m_pc + {{4{disp[7]}}, disp};
      end
      3'b101: begin
        if (func[0]) begin
          m_rs.push_back(m_pc);
          if (m_rs.size() > RS_DEPTH) begin
            void'(m_rs.pop_front());
            m_err = 1'b1;
          end
        end
        m_pc = addr;
      end
      3'b110: begin
        if (func == 3'b000) begin
          if (m_rs.size() == 0) m_err = 1'b1;
          else m_pc = m_rs.pop_back();
        end else if (func == 3'b001) halt = 1'b1;
      end
      default: m_err = 1'b1;
    endcase
    if (!halt) exp_q.push_back('{m_pc, lat});

    w = waits; rw = 0; ce = 0; dstb = 0; pstb = 0; we = 0; n = 0;
    mux = 2'b00; aluop = 4'b0000; op2 = 1'b0;
    while (n < 40) begin
      if (dut_if.inst_stb_o || dut_if.halted_o) break;
      dut_if.data_ack_i = 1'b0;
      dut_if.port_ack_i = 1'b0;
      if (dut_if.data_stb_o || dut_if.port_stb_o) begin
        if (w == 0) begin
          dut_if.data_ack_i = dut_if.data_stb_o;
          dut_if.port_ack_i = dut_if.port_stb_o;
        end else w--;
      end
      #1;
      if (dut_if.RegWrt_c) begin
        rw++;
        mux = dut_if.RegMux_c;
        aluop = dut_if.ALUOp_c;
        op2 = dut_if.op2_c;
      end
      if (dut_if.ClkEn_e) ce++;
      if (dut_if.data_stb_o) dstb++;
      if (dut_if.port_stb_o) pstb++;
      if (dut_if.bus_we_o) we++;
      @(negedge clk);
      n++;
    end
    dut_if.data_ack_i = 1'b0;
    dut_if.port_ack_i = 1'b0;
    check("run_bounded", n < 40, 1);
    check("regwrt_cycles", rw, erw);
    check("clken_cycles", ce, erw);
    check("data_stb_cycles", dstb, edstb);
    check("port_stb_cycles", pstb, epstb);
    check("bus_we_cycles", we, ewe);
    check("err_o", dut_if.err_o, m_err);
    check("halted_o", dut_if.halted_o, halt);
    if (erw > 0) begin
      check("regmux", mux, emux);
      check("aluop", aluop, ealu);
      check("op2", op2, eop2);
    end
  endtask

  initial begin
    int quiet;
    logic [11:0] tgt;

    // sequential fetch, wrap past FFF, branches, bus cycles
    do_reset();
    for (int i = 0; i < 6; i++) run_inst(3'b001, 3'b000, 12'h0, 8'h0, 1'b0, 1'b0, 0);
    run_inst(3'b101, 3'b000, 12'hFFE, 8'h0, 1'b0, 1'b0, 0);
    run_inst(3'b001, 3'b000, 12'h0, 8'h0, 1'b0, 1'b0, 0);
    run_inst(3'b001, 3'b000, 12'h0, 8'h0, 1'b0, 1'b0, 0);
    run_inst(3'b101, 3'b000, 12'h00F, 8'h0, 1'b0, 1'b0, 0);
    run_inst(3'b000, 3'b011, 12'h0, 8'h0, 1'b1, 1'b0, 0);
    run_inst(3'b100, 3'b000, 12'h0, 8'hFC, 1'b0, 1'b0, 0);
    run_inst(3'b100, 3'b001, 12'h0, 8'hFC, 1'b0, 1'b0, 0);
    run_inst(3'b010, 3'b110, 12'h0, 8'h0, 1'b0, 1'b1, 0);
    run_inst(3'b100, 3'b010, 12'h0, 8'h05, 1'b0, 1'b0, 0);
    run_inst(3'b100, 3'b011, 12'h0, 8'h05, 1'b0, 1'b0, 0);
    run_inst(3'b100, 3'b000, 12'h0, 8'h80, 1'b0, 1'b0, 0);
    run_inst(3'b011, 3'b000, 12'h0, 8'h0, 1'b0, 1'b0, 3);
    run_inst(3'b011, 3'b011, 12'h0, 8'h0, 1'b0, 1'b0, 0);
    run_inst(3'b011, 3'b010, 12'h0, 8'h0, 1'b0, 1'b0, 1);
    run_inst(3'b011, 3'b001, 12'h0, 8'h0, 1'b0, 1'b0, 0);
    run_inst(3'b110, 3'b101, 12'h0, 8'h0, 1'b0, 1'b0, 0);
    run_inst(3'b011, 3'b100, 12'h0, 8'h0, 1'b0, 1'b0, 0);
    run_inst(3'b001, 3'b001, 12'h0, 8'h0, 1'b0, 1'b0, 0);

    // return stack overflow, LIFO returns, underflow
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tgt = 12'h100 + 12'(i * 16);
      run_inst(3'b101, 3'b001, tgt, 8'h0, 1'b0, 1'b0, 0);
    end
    for (int i = 0; i < 9; i++) run_inst(3'b110, 3'b000, 12'h0, 8'h0, 1'b0, 1'b0, 0);
    run_inst(3'b001, 3'b000, 12'h0, 8'h0, 1'b0, 1'b0, 0);

    // illegal op, then standby with acks offered
    do_reset();
    run_inst(3'b111, 3'b000, 12'h0, 8'h0, 1'b0, 1'b0, 0);
    run_inst(3'b110, 3'b001, 12'h0, 8'h0, 1'b0, 1'b0, 0);
    dut_if.inst_ack_i = 1'b1;
    dut_if.data_ack_i = 1'b1;
    quiet = 0;
    repeat (50) begin
      @(negedge clk);
      if (dut_if.inst_stb_o || dut_if.data_stb_o || dut_if.port_stb_o || dut_if.RegWrt_c || dut_if.ClkEn_e)
        quiet++;
    end
    dut_if.inst_ack_i = 1'b0;
    dut_if.data_ack_i = 1'b0;
    check("halt_quiet", quiet, 0);
    check("halt_state", dut_if.state_o, 5);
    check("halt_flags", {dut_if.halted_o, dut_if.err_o}, 2'b11);

    // reset while a load waits for its ack
    do_reset();
    check("d_fetch_adr", dut_if.inst_adr_o, 0);
    dut_if.op_e = 3'b011;
    dut_if.func_e = 3'b000;
    dut_if.inst_ack_i = 1'b1;
    @(negedge clk);
    dut_if.inst_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    check("mem_wait_stb", dut_if.data_stb_o, 1);
    #1 rst = 1'b1;
    #1 check("rst_drops_stb", {dut_if.data_stb_o, dut_if.inst_stb_o}, 0);
    dut_if.data_ack_i = 1'b1;
    #1 check("rst_no_write", {dut_if.RegWrt_c, dut_if.ClkEn_e}, 0);
    @(negedge clk);
    rst = 1'b0;
    dut_if.data_ack_i = 1'b0;
    #1 check("rst_pc_zero", dut_if.inst_adr_o, 0);
    check("rst_state_fetch", dut_if.state_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
